// File: rtl/screen_arb_pkg.sv
// Shared types and constants for the screen framebuffer arbiter.
package screen_arb_pkg;

    localparam int unsigned SCREEN_ADDR_W = 13;
    localparam int unsigned SCREEN_DATA_W = 16;
    localparam int unsigned FB_BASE       = 16384;
    localparam int unsigned FB_SIZE       = 8192;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD       = 2'd1,
        WR       = 2'd2,
        FORCE_WR = 2'd3
    } arb_state_e;

    function automatic logic is_write_grant(input arb_state_e grant);
        return (grant == WR) || (grant == FORCE_WR);
    endfunction

endpackage

// File: rtl/screen_wr_fifo.sv
// CPU write buffer for the screen arbiter: synchronous FIFO of {address, data}.
// With SCREEN_ARB_COALESCE_EN defined, a write hitting the tail address overwrites the tail data.
module screen_wr_fifo
    import screen_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = SCREEN_ADDR_W,
    parameter int unsigned DATA_W = SCREEN_DATA_W,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_req_i,
    input  logic [ADDR_W-1:0]            wr_addr_i,
    input  logic [DATA_W-1:0]            wr_data_i,
    input  logic                         pop_i,
    output logic [ADDR_W-1:0]            head_addr_o,
    output logic [DATA_W-1:0]            head_data_o,
    output logic                         tail_match_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic                         drop_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] addr_mem_q [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  tail_ptr_s;
    logic              full_s;
    logic              empty_s;
    logic              coalesce_s;
    logic              push_s;

    assign full_s       = (count_q == CNT_W'(DEPTH));
    assign empty_s      = (count_q == {CNT_W{1'b0}});
    assign tail_ptr_s   = wr_ptr_q - PTR_W'(1);
    assign tail_match_o = !empty_s && (addr_mem_q[tail_ptr_s] == wr_addr_i);

    // Write acceptance: coalesce into the tail, push a new entry, or drop
    always_comb begin
        coalesce_s = 1'b0;
        push_s     = 1'b0;
        drop_o     = 1'b0;
`ifdef SCREEN_ARB_COALESCE_EN
        // The tail must survive this cycle's pop for the overwrite to land
        if (wr_req_i && tail_match_o && !((count_q == CNT_W'(1)) && pop_i)) begin
            coalesce_s = 1'b1;
        end else begin
            coalesce_s = 1'b0;
        end
`endif
        if (wr_req_i && !coalesce_s) begin
            push_s = !full_s;
            drop_o = full_s;
        end else begin
            push_s = 1'b0;
            drop_o = 1'b0;
        end
    end

    // Pointer and occupancy next state
    always_comb begin
        wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop_i  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        count_d  = count_q;
        case ({push_s, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (push_s) begin
            addr_mem_q[wr_ptr_q] <= wr_addr_i;
            data_mem_q[wr_ptr_q] <= wr_data_i;
        end else if (coalesce_s) begin
            data_mem_q[tail_ptr_s] <= wr_data_i;
        end
    end

    assign head_addr_o = addr_mem_q[rd_ptr_q];
    assign head_data_o = data_mem_q[rd_ptr_q];
    assign count_o     = count_q;
    assign full_o      = full_s;
    assign empty_o     = empty_s;

endmodule

// File: rtl/screen_arbiter.sv
// Single-port framebuffer arbiter: display reads win, buffered CPU writes are forced
// through after STARVE_LIMIT denied cycles. Optional macro: SCREEN_ARB_COALESCE_EN.
module screen_arbiter
    import screen_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = SCREEN_ADDR_W,
    parameter int unsigned DATA_W       = SCREEN_DATA_W,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_data,
    output logic              cpu_full,
    output logic              cpu_overflow,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_address,
    output logic              disp_ack,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_d,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
);

    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and at least 2");
    end
    if ((64'd1 << ADDR_W) > 64'(FB_SIZE)) begin : g_bad_addr
        $error("ADDR_W exceeds the framebuffer size");
    end

    arb_state_e        state_q, grant_s;
    logic [STV_W-1:0]  starve_q, starve_d;
    logic [ADDR_W-1:0] ram_address_q, ram_address_d;
    logic [DATA_W-1:0] ram_d_q, ram_d_d;
    logic              ram_we_q, ram_we_d;
    logic              disp_valid_q, disp_valid_d;
    logic              overflow_q, overflow_d;

    logic [ADDR_W-1:0] fifo_head_addr_s;
    logic [DATA_W-1:0] fifo_head_data_s;
    logic              fifo_tail_match_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              fifo_drop_s;
    logic              pop_s;
    // Occupancy and tail compare are status only at this level
    logic              fifo_status_unused_s;

    assign fifo_status_unused_s = ^{fifo_count_s, fifo_tail_match_s};

    screen_wr_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk          (clk),
        .reset        (reset),
        .wr_req_i     (cpu_we),
        .wr_addr_i    (cpu_address),
        .wr_data_i    (cpu_data),
        .pop_i        (pop_s),
        .head_addr_o  (fifo_head_addr_s),
        .head_data_o  (fifo_head_data_s),
        .tail_match_o (fifo_tail_match_s),
        .count_o      (fifo_count_s),
        .full_o       (fifo_full_s),
        .empty_o      (fifo_empty_s),
        .drop_o       (fifo_drop_s)
    );

    // Grant decision for this cycle; nothing is granted while reset is held
    always_comb begin
        grant_s = IDLE;
        if (reset) begin
            grant_s = IDLE;
        end else if (!fifo_empty_s && (starve_q == STARVE_MAX)) begin
            grant_s = FORCE_WR;
        end else if (disp_req) begin
            grant_s = RD;
        end else if (!fifo_empty_s) begin
            grant_s = WR;
        end else begin
            grant_s = IDLE;
        end
    end

    assign pop_s    = is_write_grant(grant_s);
    assign disp_ack = (grant_s == RD);

    // Next state for starvation counter, RAM port, read pipeline and overflow flag
    always_comb begin
        starve_d      = starve_q;
        ram_address_d = ram_address_q;
        ram_d_d       = ram_d_q;
        ram_we_d      = 1'b0;
        disp_valid_d  = (state_q == RD);
        overflow_d    = overflow_q | fifo_drop_s;

        if (fifo_empty_s || pop_s) begin
            starve_d = {STV_W{1'b0}};
        end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + STV_W'(1);
        end else begin
            starve_d = starve_q;
        end

        case (grant_s)
            RD: begin
                ram_address_d = disp_address;
                ram_we_d      = 1'b0;
            end
            WR, FORCE_WR: begin
                ram_address_d = fifo_head_addr_s;
                ram_d_d       = fifo_head_data_s;
                ram_we_d      = 1'b1;
            end
            IDLE: begin
                ram_we_d = 1'b0;
            end
            default: begin
                ram_we_d = 1'b0;
            end
        endcase
    end

    // Grant, RAM port and read pipeline registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            starve_q      <= {STV_W{1'b0}};
            ram_address_q <= {ADDR_W{1'b0}};
            ram_d_q       <= {DATA_W{1'b0}};
            ram_we_q      <= 1'b0;
            disp_valid_q  <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= grant_s;
            starve_q      <= starve_d;
            ram_address_q <= ram_address_d;
            ram_d_q       <= ram_d_d;
            ram_we_q      <= ram_we_d;
            disp_valid_q  <= disp_valid_d;
            overflow_q    <= overflow_d;
        end
    end

    // The RAM presents read data one cycle after the address, i.e. in the valid cycle
    assign disp_data    = disp_valid_q ? ram_q : {DATA_W{1'b0}};
    assign disp_valid   = disp_valid_q;
    assign ram_address  = ram_address_q;
    assign ram_d        = ram_d_q;
    assign ram_we       = ram_we_q;
    assign cpu_full     = fifo_full_s;
    assign cpu_overflow = overflow_q;

endmodule

// File: tb/tb_screen_arbiter.sv
// Randomised scoreboard bench for screen_arbiter against a queue-based reference model.
module tb_screen_arbiter;

    localparam int AW    = 13;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_we;
    logic [AW-1:0] cpu_address;
    logic [DW-1:0] cpu_data;
    logic          cpu_full;
    logic          cpu_overflow;
    logic          disp_req;
    logic [AW-1:0] disp_address;
    logic          disp_ack;
    logic [DW-1:0] disp_data;
    logic          disp_valid;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_d;
    logic          ram_we;
    logic [DW-1:0] ram_q;

    screen_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .FIFO_DEPTH   (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_we       (cpu_we),
        .cpu_address  (cpu_address),
        .cpu_data     (cpu_data),
        .cpu_full     (cpu_full),
        .cpu_overflow (cpu_overflow),
        .disp_req     (disp_req),
        .disp_address (disp_address),
        .disp_ack     (disp_ack),
        .disp_data    (disp_data),
        .disp_valid   (disp_valid),
        .ram_address  (ram_address),
        .ram_d        (ram_d),
        .ram_we       (ram_we),
        .ram_q        (ram_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    typedef struct {
        int            due;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } exp_t;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit model_en = 1'b0;

    logic [DW-1:0] ram_mem   [int];
    logic [DW-1:0] model_mem [int];
    wr_t  mq[$];
    exp_t wr_exp[$];
    exp_t rd_exp[$];
    int   starve = 0;
    bit   ovf    = 1'b0;

    function automatic logic [DW-1:0] preload(input int a);
        return 16'(a) ^ 16'hC35A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous single-port RAM, preloaded with a pattern
    always @(posedge clk) begin
        ram_q <= ram_mem.exists(int'(ram_address)) ? ram_mem[int'(ram_address)] : preload(int'(ram_address));
        if (ram_we === 1'b1) ram_mem[int'(ram_address)] = ram_d;
    end

    // Reference model: predicts grants, queues expected RAM writes and read returns
    always @(negedge clk) begin
        if (model_en) begin
            int  g;
            bit  nonempty;
            bit  pop;
            bit  coalesced;
            wr_t h;
            check("cpu_full", cpu_full, (mq.size() == DEPTH));
            check("cpu_overflow", cpu_overflow, ovf);
            if (reset) begin
                check("disp_ack_in_reset", disp_ack, 1'b0);
                mq.delete();
                starve = 0;
                ovf    = 1'b0;
                while (wr_exp.size() > 0 && wr_exp[$].due > cyc) void'(wr_exp.pop_back());
                while (rd_exp.size() > 0 && rd_exp[$].due > cyc) void'(rd_exp.pop_back());
            end else begin
                nonempty = (mq.size() > 0);
                if (nonempty && starve >= LIMIT) g = 2;
                else if (disp_req)               g = 1;
                else if (nonempty)               g = 2;
                else                             g = 0;
                check("disp_ack", disp_ack, (g == 1));
                pop = (g == 2);
                if (g == 1) begin
                    rd_exp.push_back('{cyc + 2, disp_address,
                        model_mem.exists(int'(disp_address)) ? model_mem[int'(disp_address)] : preload(int'(disp_address))});
                end
                if (pop) begin
                    h = mq[0];
                    wr_exp.push_back('{cyc + 1, h.a, h.d});
                    model_mem[int'(h.a)] = h.d;
                end
                if (!nonempty || pop) starve = 0;
                else if (starve < LIMIT) starve++;
                if (cpu_we) begin
                    coalesced = 1'b0;
`ifdef SCREEN_ARB_COALESCE_EN
                    if (mq.size() >= 1 && !(mq.size() == 1 && pop) && mq[$].a == cpu_address) begin
                        mq[$].d   = cpu_data;
                        coalesced = 1'b1;
                    end
`endif
                    if (!coalesced) begin
                        if (mq.size() == DEPTH) ovf = 1'b1;
                        else mq.push_back('{cpu_address, cpu_data});
                    end
                end
                if (pop) void'(mq.pop_front());
            end
        end
    end

    // Monitor: pops expectations when the DUT presents a RAM write or read data
    always @(negedge clk) begin
        if (model_en) begin
            exp_t e;
            if (ram_we === 1'b1) begin
                if (wr_exp.size() == 0) begin
                    check("ram_we_unexpected", ram_we, 1'b0);
                end else begin
                    e = wr_exp.pop_front();
                    check("wr_cycle", cyc, e.due);
                    check("ram_address", ram_address, e.a);
                    check("ram_d", ram_d, e.d);
                end
            end else if (wr_exp.size() > 0 && wr_exp[0].due <= cyc) begin
                e = wr_exp.pop_front();
                check("ram_we_missing", ram_we, 1'b1);
            end
            if (disp_valid === 1'b1) begin
                if (rd_exp.size() == 0) begin
                    check("disp_valid_unexpected", disp_valid, 1'b0);
                end else begin
                    e = rd_exp.pop_front();
                    check("rd_cycle", cyc, e.due);
                    check("disp_data", disp_data, e.d);
                end
            end else if (rd_exp.size() > 0 && rd_exp[0].due <= cyc) begin
                e = rd_exp.pop_front();
                check("disp_valid_missing", disp_valid, 1'b1);
            end
        end
    end

    initial begin
        int ack_cnt;
        reset = 1'b1; cpu_we = 1'b0; cpu_address = '0; cpu_data = '0;
        disp_req = 1'b0; disp_address = '0;
        tick();
        model_en = 1'b1;
        tick();
        @(negedge clk);
        check("rst_ram_we", ram_we, 1'b0);
        check("rst_ram_address", ram_address, 13'h0000);
        check("rst_ram_d", ram_d, 16'h0000);
        check("rst_disp_valid", disp_valid, 1'b0);
        check("rst_disp_data", disp_data, 16'h0000);
        tick();
        reset = 1'b0;

        // single write with no reads
        cpu_we = 1'b1; cpu_address = 13'h0005; cpu_data = 16'hA5A5;
        tick();
        cpu_we = 1'b0;
        repeat (5) tick();

        // one pending write against a continuous read stream
        ack_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            cpu_we = (k == 0); cpu_address = 13'h0010; cpu_data = 16'h1234;
            disp_req = 1'b1; disp_address = 13'(40 + k);
            @(negedge clk);
            ack_cnt += int'(disp_ack);
            tick();
        end
        check("starve_ack_count", ack_cnt, 19);
        cpu_we = 1'b0; disp_req = 1'b0;
        repeat (4) tick();

        // overfill while reads block
        disp_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cpu_we = 1'b1; cpu_address = 13'(32 + k); cpu_data = 16'(16'hB000 + k);
            disp_address = 13'(k);
            tick();
        end
        cpu_we = 1'b0;
        @(negedge clk);
        check("ovf_full", cpu_full, 1'b1);
        check("ovf_set", cpu_overflow, 1'b1);
        repeat (40) tick();
        disp_req = 1'b0;
        repeat (8) tick();
        @(negedge clk);
        check("ovf_sticky", cpu_overflow, 1'b1);
        tick();

        // back-to-back reads of the preloaded words 0..3
        for (int k = 0; k < 4; k++) begin
            disp_req = 1'b1; disp_address = 13'(k);
            tick();
        end
        disp_req = 1'b0;
        repeat (4) tick();

        // reset one cycle after a read is acked, with the FIFO full
        disp_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cpu_we = 1'b1; cpu_address = 13'(48 + k); cpu_data = 16'(16'hC000 + k);
            disp_address = 13'(100 + k);
            tick();
        end
        cpu_we = 1'b0; disp_address = 13'h0007;
        tick();
        reset = 1'b1; disp_req = 1'b0;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_full", cpu_full, 1'b0);
        check("post_rst_ram_we", ram_we, 1'b0);
        check("post_rst_valid", disp_valid, 1'b0);
        repeat (3) tick();

        // repeated writes to one address while reads block
        disp_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cpu_we = 1'b1; cpu_address = 13'h0100; cpu_data = 16'(k + 1);
            disp_address = 13'(200 + k);
            tick();
        end
        cpu_we = 1'b0;
        @(negedge clk);
`ifdef SCREEN_ARB_COALESCE_EN
        check("coalesce_full", cpu_full, 1'b0);
        check("coalesce_ovf", cpu_overflow, 1'b0);
`else
        check("same_addr_full", cpu_full, 1'b1);
        check("same_addr_ovf", cpu_overflow, 1'b1);
`endif
        repeat (20) tick();
        disp_req = 1'b0;
        repeat (10) tick();

        // random traffic
        for (int k = 0; k < 600; k++) begin
            cpu_we       = ($urandom % 3 == 0);
            cpu_address  = 13'($urandom % 16);
            cpu_data     = 16'($urandom);
            disp_req     = ($urandom % 4 != 0);
            disp_address = 13'($urandom % 16);
            reset        = ($urandom % 200 == 0);
            tick();
        end
        reset = 1'b0; cpu_we = 1'b0; disp_req = 1'b0;
        repeat (30) tick();
        @(negedge clk);
        check("wr_queue_drained", wr_exp.size(), 0);
        check("rd_queue_drained", rd_exp.size(), 0);
        check("model_fifo_drained", mq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
